// File: rtl/apb_obi_pkg.sv
// Shared types and helpers for the APB-to-OBI bridge: FSM state encoding,
// the full byte-enable constant and setup-phase decode helpers.
package apb_obi_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RESP = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  localparam logic [3:0] BE_ALL = 4'hF;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

  // Reads always fetch the whole word; writes honour the APB strobes.
  function automatic logic [3:0] setup_be(input logic write, input logic [3:0] strb);
    return write ? strb : BE_ALL;
  endfunction

endpackage

// File: rtl/apb_to_obi_intf.sv
// APB subordinate to OBI manager bridge: one APB transfer becomes one OBI
// transaction, with PREADY held low until the OBI response has been captured.
module apb_to_obi_intf
  import apb_obi_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // APB subordinate port
  input  logic [ADDR_W-1:0] apb_paddr_i,
  input  logic              apb_psel_i,
  input  logic              apb_penable_i,
  input  logic              apb_pwrite_i,
  input  logic [DATA_W-1:0] apb_pwdata_i,
  input  logic [3:0]        apb_pstrb_i,
  input  logic [2:0]        apb_pprot_i,
  output logic [DATA_W-1:0] apb_prdata_o,
  output logic              apb_pready_o,
  output logic              apb_pslverr_o,
  // OBI manager port
  output logic              obi_req_o,
  input  logic              obi_gnt_i,
  output logic [ADDR_W-1:0] obi_addr_o,
  output logic              obi_we_o,
  output logic [3:0]        obi_be_o,
  output logic [DATA_W-1:0] obi_wdata_o,
  input  logic              obi_rvalid_i,
  input  logic [DATA_W-1:0] obi_rdata_i,
  input  logic              obi_err_i
);

  state_e              r_state;
  state_e              w_next_state;

  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_be;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic                w_setup;
  logic                w_misaligned;
  logic                w_capture;
  logic                w_resp_take;
  logic                w_unused;

  assign w_setup      = apb_psel_i & ~apb_penable_i;
  assign w_misaligned = CHECK_ALIGN & ~is_aligned(apb_paddr_i[1:0]);
  assign w_capture    = (r_state == IDLE) & w_setup;
  // A response is only meaningful once the request has been granted.
  assign w_resp_take  = (r_state == RESP) & obi_rvalid_i;
  assign w_unused     = ^apb_pprot_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the block order cannot change behaviour.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: default assignment first so every path drives w_next_state and no
  // latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_setup) begin
          w_next_state = w_misaligned ? ERR : REQ;
        end
      end
      REQ: begin
        if (obi_gnt_i) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        if (obi_rvalid_i) begin
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      ERR:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request fields are frozen at setup so they stay stable across gnt waits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr  <= apb_paddr_i;
        r_we    <= apb_pwrite_i;
        r_wdata <= apb_pwdata_i;
        r_be    <= setup_be(apb_pwrite_i, apb_pstrb_i);
      end
      if (w_resp_take) begin
        r_rdata <= r_we ? '0 : obi_rdata_i;
        r_err   <= obi_err_i;
      end
    end
  end

  always_comb begin
    obi_req_o     = 1'b0;
    apb_pready_o  = 1'b0;
    apb_pslverr_o = 1'b0;
    apb_prdata_o  = '0;
    case (r_state)
      REQ: begin
        obi_req_o = 1'b1;
      end
      DONE: begin
        apb_pready_o  = 1'b1;
        apb_pslverr_o = r_err;
        apb_prdata_o  = r_rdata;
      end
      ERR: begin
        apb_pready_o  = 1'b1;
        apb_pslverr_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign obi_addr_o  = r_addr;
  assign obi_we_o    = r_we;
  assign obi_be_o    = r_be;
  assign obi_wdata_o = r_wdata;

endmodule

// File: tb/tb_apb_to_obi_intf.sv
// Directed bench for apb_to_obi_intf: a vector table run through an APB
// master / OBI subordinate model, plus reset and back-to-back sequences.
module tb_apb_to_obi_intf;

  localparam logic [31:0] GARBAGE = 32'hA5A5_A5A5;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] apb_paddr_i = '0;
  logic        apb_psel_i = 1'b0;
  logic        apb_penable_i = 1'b0;
  logic        apb_pwrite_i = 1'b0;
  logic [31:0] apb_pwdata_i = '0;
  logic [3:0]  apb_pstrb_i = '0;
  logic [2:0]  apb_pprot_i = 3'b010;
  logic [31:0] apb_prdata_o;
  logic        apb_pready_o;
  logic        apb_pslverr_o;
  logic        obi_req_o;
  logic        obi_gnt_i = 1'b0;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i = 1'b0;
  logic [31:0] obi_rdata_i = GARBAGE;
  logic        obi_err_i = 1'b0;

  apb_to_obi_intf #(.ADDR_W(32), .DATA_W(32), .CHECK_ALIGN(1'b1)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .apb_paddr_i   (apb_paddr_i),
    .apb_psel_i    (apb_psel_i),
    .apb_penable_i (apb_penable_i),
    .apb_pwrite_i  (apb_pwrite_i),
    .apb_pwdata_i  (apb_pwdata_i),
    .apb_pstrb_i   (apb_pstrb_i),
    .apb_pprot_i   (apb_pprot_i),
    .apb_prdata_o  (apb_prdata_o),
    .apb_pready_o  (apb_pready_o),
    .apb_pslverr_o (apb_pslverr_o),
    .obi_req_o     (obi_req_o),
    .obi_gnt_i     (obi_gnt_i),
    .obi_addr_o    (obi_addr_o),
    .obi_we_o      (obi_we_o),
    .obi_be_o      (obi_be_o),
    .obi_wdata_o   (obi_wdata_o),
    .obi_rvalid_i  (obi_rvalid_i),
    .obi_rdata_i   (obi_rdata_i),
    .obi_err_i     (obi_err_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc   = 0;
  int n_gnt = 0;
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (obi_req_o && obi_gnt_i) n_gnt <= n_gnt + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          gnt_dly;
    int          rv_dly;
    bit          spur_rv;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  exp_be;
    int          exp_lat;
    int          exp_reqs;
    logic [31:0] exp_prdata;
    logic        exp_slverr;
  } vec_t;

  // One APB transfer with a cooperating OBI subordinate. Must be entered at
  // a negedge; leaves at the negedge of the IDLE cycle after PREADY, so a
  // following call issues its setup phase back-to-back.
  task automatic xfer(input vec_t v, input string name, output int pready_cyc);
    int  t          = 0;
    int  lat        = -1;
    int  reqs       = 0;
    int  rcnt       = 0;
    int  bad_fields = 0;
    int  bad_idle   = 0;
    bit  granted    = 1'b0;
    logic [31:0] prdata_seen = '0;
    logic        slverr_seen = 1'b0;
    pready_cyc    = -1;
    apb_psel_i    = 1'b1;
    apb_penable_i = 1'b0;
    apb_paddr_i   = v.addr;
    apb_pwrite_i  = v.write;
    apb_pwdata_i  = v.wdata;
    apb_pstrb_i   = v.strb;
    obi_gnt_i     = 1'b0;
    obi_rvalid_i  = 1'b0;
    obi_rdata_i   = GARBAGE;
    obi_err_i     = 1'b0;
    while (lat < 0 && t < 60) begin
      @(negedge clk_i);
      t++;
      apb_penable_i = 1'b1;
      if (apb_pready_o) begin
        lat         = t;
        pready_cyc  = cyc;
        prdata_seen = apb_prdata_o;
        slverr_seen = apb_pslverr_o;
      end else if (apb_pslverr_o || apb_prdata_o != 32'h0) begin
        bad_idle++;
      end
      obi_gnt_i    = 1'b0;
      obi_rvalid_i = 1'b0;
      obi_rdata_i  = GARBAGE;
      obi_err_i    = 1'b0;
      if (granted) begin
        rcnt++;
        if (rcnt == v.rv_dly + 1) begin
          obi_rvalid_i = 1'b1;
          obi_rdata_i  = v.rdata;
          obi_err_i    = v.err;
        end
      end
      if (obi_req_o) begin
        reqs++;
        if (obi_addr_o != v.addr || obi_we_o != v.write || obi_be_o != v.exp_be ||
            (v.write && obi_wdata_o != v.wdata)) bad_fields++;
        if (reqs == v.gnt_dly + 1) begin
          obi_gnt_i = 1'b1;
          granted   = 1'b1;
          if (v.spur_rv) begin
            obi_rvalid_i = 1'b1;
            obi_rdata_i  = 32'h5555_5555;
          end
        end
      end
    end
    check({name, ".latency"}, lat, v.exp_lat);
    check({name, ".prdata"}, prdata_seen, v.exp_prdata);
    check({name, ".pslverr"}, {31'h0, slverr_seen}, {31'h0, v.exp_slverr});
    check({name, ".req_cycles"}, reqs, v.exp_reqs);
    check({name, ".req_fields_bad"}, bad_fields, 0);
    check({name, ".resp_outside_pready"}, bad_idle, 0);
    @(negedge clk_i);
    check({name, ".pready_one_cycle"}, {31'h0, apb_pready_o}, 32'h0);
    apb_psel_i    = 1'b0;
    apb_penable_i = 1'b0;
    obi_gnt_i     = 1'b0;
    obi_rvalid_i  = 1'b0;
    obi_rdata_i   = GARBAGE;
    obi_err_i     = 1'b0;
  endtask

  vec_t vecs[9];
  vec_t b2b0, b2b1, post_rst;

  initial begin
    int pc0, pc1, g0, dummy;

    //            addr          wr    wdata         strb    gd rd sp rdata         err   be      lat reqs prdata        slverr
    vecs[0] = '{32'h1000_0004, 1'b0, 32'h0BAD_0BAD, 4'b0011, 0, 0, 0, 32'hDEAD_BEEF, 1'b0, 4'hF,    3, 1, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{32'h0000_0040, 1'b1, 32'h1234_5678, 4'b0101, 3, 2, 0, 32'hCAFE_F00D, 1'b0, 4'b0101, 8, 4, 32'h0000_0000, 1'b0};
    vecs[2] = '{32'h0000_0008, 1'b0, 32'h0000_0000, 4'b0000, 0, 0, 0, 32'hFFFF_FFFF, 1'b1, 4'hF,    3, 1, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{32'h0000_0102, 1'b0, 32'h0000_0000, 4'b1111, 0, 0, 0, 32'h1111_1111, 1'b0, 4'hF,    1, 0, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_0003, 1'b1, 32'h7777_0000, 4'b1111, 0, 0, 0, 32'h1111_1111, 1'b0, 4'hF,    1, 0, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h0000_0100, 1'b1, 32'h0000_1111, 4'b1111, 1, 0, 0, 32'h2222_2222, 1'b1, 4'hF,    4, 2, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 4'b1000, 0, 3, 0, 32'h0BAD_F00D, 1'b0, 4'hF,    6, 1, 32'h0BAD_F00D, 1'b0};
    vecs[7] = '{32'h0000_0200, 1'b1, 32'h8000_0001, 4'b0000, 0, 1, 0, 32'h3333_3333, 1'b0, 4'b0000, 4, 1, 32'h0000_0000, 1'b0};
    vecs[8] = '{32'h0000_0044, 1'b0, 32'h0000_0000, 4'b0000, 0, 1, 1, 32'h7777_7777, 1'b0, 4'hF,    4, 1, 32'h7777_7777, 1'b0};

    b2b0     = '{32'h0000_0000, 1'b0, 32'h0, 4'b0000, 0, 0, 0, 32'hA0A0_0000, 1'b0, 4'hF, 3, 1, 32'hA0A0_0000, 1'b0};
    b2b1     = '{32'h0000_0004, 1'b0, 32'h0, 4'b0000, 0, 0, 0, 32'hB0B0_0004, 1'b0, 4'hF, 3, 1, 32'hB0B0_0004, 1'b0};
    post_rst = '{32'h0000_0020, 1'b0, 32'h0, 4'b0000, 0, 0, 0, 32'h2020_2020, 1'b0, 4'hF, 3, 1, 32'h2020_2020, 1'b0};

    // Reset values while reset is held
    #1;
    check("reset.outputs_zero",
          {31'h0, |{apb_pready_o, apb_pslverr_o, apb_prdata_o, obi_req_o,
                    obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o}}, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    foreach (vecs[i]) xfer(vecs[i], $sformatf("vec%0d", i), dummy);

    // Back-to-back reads: second setup lands in the IDLE cycle after DONE
    g0 = n_gnt;
    xfer(b2b0, "b2b0", pc0);
    xfer(b2b1, "b2b1", pc1);
    check("b2b.pready_spacing", pc1 - pc0, 4);
    check("b2b.grant_count", n_gnt - g0, 2);

    // Reset while waiting in RESP
    apb_psel_i    = 1'b1;
    apb_penable_i = 1'b0;
    apb_paddr_i   = 32'h0000_0030;
    apb_pwrite_i  = 1'b0;
    @(negedge clk_i);
    apb_penable_i = 1'b1;
    check("rst_resp.req_before", {31'h0, obi_req_o}, 32'h1);
    obi_gnt_i = 1'b1;
    @(negedge clk_i);
    obi_gnt_i = 1'b0;
    check("rst_resp.addr_before", obi_addr_o, 32'h0000_0030);
    #2 rst_i = 1'b1;
    #1;
    check("rst_resp.outputs_zero",
          {31'h0, |{apb_pready_o, apb_pslverr_o, apb_prdata_o, obi_req_o,
                    obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o}}, 32'h0);
    check("rst_resp.addr_cleared", obi_addr_o, 32'h0);
    apb_psel_i    = 1'b0;
    apb_penable_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    // A stale response after reset must not produce an APB completion
    obi_rvalid_i = 1'b1;
    obi_rdata_i  = 32'h9999_9999;
    @(negedge clk_i);
    obi_rvalid_i = 1'b0;
    obi_rdata_i  = GARBAGE;
    check("rst_resp.no_pready", {31'h0, apb_pready_o}, 32'h0);
    @(negedge clk_i);
    check("rst_resp.no_pready_later", {31'h0, apb_pready_o}, 32'h0);
    xfer(post_rst, "post_rst", dummy);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_to_obi_intf.md
Name: apb_to_obi_intf

Overview:
- Bridges an APB subordinate port onto an OBI manager port.
- Lets an APB-only initiator (debug/test APB master, external APB bridge) reach OBI-attached memories and peripherals.
- Each APB transfer becomes exactly one OBI transaction, at most one outstanding.
- APB access phase is extended (PREADY low) until the OBI response returns.

Parameters:
- ADDR_W, 32, address width of both paddr and obi_addr_o.
- DATA_W, 32, data width. Only 32 is supported.
- CHECK_ALIGN, 1, when 1 an unaligned paddr (paddr[1:0]!=0) is rejected with PSLVERR and no OBI request is issued.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- apb_paddr_i  in  ADDR_W  APB address.
- apb_psel_i  in  1  APB select.
- apb_penable_i  in  1  APB enable.
- apb_pwrite_i  in  1  APB write.
- apb_pwdata_i  in  32  APB write data.
- apb_pstrb_i  in  4  APB write strobes.
- apb_pprot_i  in  3  ignored.
- apb_prdata_o  out  32  APB read data.
- apb_pready_o  out  1  APB ready.
- apb_pslverr_o  out  1  APB error.
- obi_req_o  out  1  OBI request.
- obi_gnt_i  in  1  OBI grant.
- obi_addr_o  out  ADDR_W  OBI address.
- obi_we_o  out  1  OBI write enable.
- obi_be_o  out  4  OBI byte enables.
- obi_wdata_o  out  32  OBI write data.
- obi_rvalid_i  in  1  OBI response valid.
- obi_rdata_i  in  32  OBI read data.
- obi_err_i  in  1  OBI response error.

Behaviour:
- Reset (rst_i high, async): state=IDLE; all outputs 0; captured addr/wdata/be/we/rdata/err registers cleared.
- Reset asserted mid-transfer: transfer is abandoned immediately. PREADY stays 0 and no response is produced.
- States:
  - IDLE: PREADY=0, obi_req_o=0. On psel & !penable (setup phase), capture paddr, pwrite, pwdata, and be. be = pstrb on write, 4'hF on read. If CHECK_ALIGN and paddr[1:0]!=0, go to ERR; otherwise go to REQ.
  - REQ: obi_req_o=1. Address, we, be and wdata are driven from the capture registers and held stable until grant. On obi_gnt_i go to RESP. obi_req_o is never withdrawn before grant.
  - RESP: obi_req_o=0. On obi_rvalid_i, register rdata (reads only; writes leave prdata at 0) and err, then go to DONE.
  - DONE: PREADY=1 for exactly one cycle. prdata and pslverr come from registers. Go to IDLE.
  - ERR: PREADY=1 and PSLVERR=1 for one cycle, prdata=0. Go to IDLE.
- PREADY, PSLVERR and prdata are all registered-state outputs. PSLVERR and prdata are valid only while PREADY=1 and are 0 otherwise.
- Latency, gnt and rvalid at earliest:
  - setup cycle T0, REQ T1, RESP T2, DONE T3.
  - PREADY high at T3, giving a 4-cycle APB transfer minimum.
  - Each gnt or rvalid wait cycle adds one cycle.
- obi_rvalid_i arriving in the same cycle as obi_gnt_i is not legal OBI and is ignored; RESP waits for a later rvalid.
- Responses arriving in IDLE/REQ/DONE/ERR are ignored.
- APB protocol violation (psel dropped mid-transfer): the OBI transaction still completes and the DONE pulse is still emitted. No hang.
- Back-to-back transfers: a new setup phase is accepted in the cycle after DONE (IDLE). No pipelining.

Decomposition:
- Shared package apb_obi_pkg: state_e enum {IDLE, REQ, RESP, DONE, ERR}, 3-bit; constant BE_ALL = 4'hF.
- No sub-module; a single FSM plus capture registers.

Test Plan:
- Read, zero-wait: paddr=0x1000_0004, gnt at T1, rvalid at T2 with rdata=0xDEAD_BEEF → obi_addr_o=0x1000_0004, be=4'hF, we=0; pready at T3, prdata=0xDEAD_BEEF, pslverr=0.
- Write with strobes and wait states: pwdata=0x1234_5678, pstrb=4'b0101, gnt delayed 3 cycles, rvalid delayed 2 → req held stable 4 cycles with be=4'b0101; pready exactly 1 cycle at T8; prdata=0.
- Error response: read with obi_err_i=1 and rdata=0xFFFF_FFFF → pslverr=1 and prdata=0xFFFF_FFFF for one pready cycle.
- Unaligned access, CHECK_ALIGN=1: paddr=0x0000_0102 → obi_req_o never asserted; pready=1 and pslverr=1 at T1.
- Reset during RESP: rst_i pulsed while waiting for rvalid → all outputs 0 immediately; a following read of 0x20 completes normally with 4-cycle latency.
- Back-to-back: two reads to 0x0 and 0x4 with zero-wait OBI → exactly two obi_req_o grants; pready pulses at T3 and T7, matching rdata for each.
